// File: rtl/alu_mul_seq.sv
// ---------------------------------------------------------------------------
// alu_mul_seq
// Sequential radix-2 shift-and-add unsigned 64x64 multiplier. Each operation
// runs for exactly 64 iterations and reports the low 64 bits of the product
// plus a flag telling whether the full 128-bit product reached 2^64.
//
// Ports
//   clk      in   1  rising-edge clock
//   rst_n    in   1  asynchronous active-low reset
//   start    in   1  operation request, accepted in IDLE or DONE
//   a        in  64  unsigned multiplicand, latched on accept
//   b        in  64  unsigned multiplier, latched on accept
//   busy     out  1  high while an operation is iterating
//   done     out  1  one-cycle pulse, product/overflow valid
//   product  out 64  low 64 bits of a*b
//   overflow out  1  full product a*b >= 2^64
// ---------------------------------------------------------------------------
module alu_mul_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] product,
    output logic        overflow
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [63:0] r_acc;
    logic [63:0] r_mcand;
    logic [63:0] r_mplier;
    logic [5:0]  r_cnt;
    logic        r_lost;
    logic        r_ovf;
    logic        r_busy;
    logic        r_done;
    logic [63:0] r_product;
    logic        r_overflow;

    logic        w_accept;
    logic [64:0] w_sum;
    logic [63:0] w_acc_next;
    logic        w_ovf_next;
    logic        w_lost_next;

    // Next-iteration datapath: conditional add and sticky overflow/lost-bit update
    always_comb begin
        w_accept    = 1'b0;
        w_sum       = {1'b0, r_acc} + {1'b0, r_mcand};
        w_acc_next  = r_acc;
        w_ovf_next  = r_ovf;
        w_lost_next = r_lost | r_mcand[63];
        if ((r_state == ST_IDLE) || (r_state == ST_DONE)) begin
            w_accept = start;
        end else begin
            w_accept = 1'b0;
        end
        // The lost flag means an earlier shift already dropped a set bit, so
        // the multiplicand term being added is really >= 2^64.
        if (r_mplier[0]) begin
            w_acc_next = w_sum[63:0];
            w_ovf_next = r_ovf | w_sum[64] | r_lost;
        end else begin
            w_acc_next = r_acc;
            w_ovf_next = r_ovf;
        end
    end

    // Control FSM, iteration datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_acc      <= 64'd0;
            r_mcand    <= 64'd0;
            r_mplier   <= 64'd0;
            r_cnt      <= 6'd0;
            r_lost     <= 1'b0;
            r_ovf      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_product  <= 64'd0;
            r_overflow <= 1'b0;
        end else if (w_accept) begin
            r_state  <= ST_RUN;
            r_acc    <= 64'd0;
            r_mcand  <= a;
            r_mplier <= b;
            r_cnt    <= 6'd0;
            r_lost   <= 1'b0;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                end
                ST_RUN: begin
                    r_acc    <= w_acc_next;
                    r_ovf    <= w_ovf_next;
                    r_lost   <= w_lost_next;
                    r_mcand  <= {r_mcand[62:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[63:1]};
                    r_cnt    <= r_cnt + 6'd1;
                    if (r_cnt == 6'd63) begin
                        r_state    <= ST_DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_product  <= w_acc_next;
                        r_overflow <= w_ovf_next;
                    end else begin
                        r_busy <= 1'b1;
                        r_done <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign product  = r_product;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_alu_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_mul_seq
// Self-checking bench for alu_mul_seq. Expected results come from a 128-bit
// reference product and are queued when an operation is launched; they are
// popped and compared when done pulses.
// ---------------------------------------------------------------------------
module tb_alu_mul_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] a;
    logic [63:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic        overflow;

    typedef struct packed {
        logic [63:0] p;
        logic        o;
    } exp_t;

    exp_t sb_q[$];
    int   pass_cnt;
    int   total_cnt;

    alu_mul_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .product  (product),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t ref_model(input logic [63:0] x, input logic [63:0] y);
        logic [127:0] full;
        exp_t         e;
        full = {64'd0, x} * {64'd0, y};
        e.p  = full[63:0];
        e.o  = (full[127:64] != 64'd0);
        return e;
    endfunction

    // Launch one operation: start seen on the next edge, returns just after it.
    task automatic drive_start(input logic [63:0] x, input logic [63:0] y, input bit push);
        a     = x;
        b     = y;
        start = 1'b1;
        if (push) sb_q.push_back(ref_model(x, y));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges until done is seen; records whether busy stayed high before it.
    task automatic wait_done(output int n, output bit busy_ok);
        n       = 0;
        busy_ok = 1'b1;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (done === 1'b1) break;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a     = 64'd0;
        b     = 64'd0;
        #23;
        total_cnt++;
        if ({busy, done, product, overflow} !== 67'd0)
            $display("FAIL reset_outputs: got busy=%b done=%b product=%h ovf=%b, want all 0", busy, done, product, overflow);
        else pass_cnt++;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({busy, done} !== 2'b00)
            $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
        else pass_cnt++;
    endtask

    // Single operation: checks busy, latency, result, and the done pulse width.
    task automatic test_op(input string nm, input logic [63:0] x, input logic [63:0] y);
        int   n;
        bit   bok;
        exp_t e;
        drive_start(x, y, 1'b1);
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL %s_busy_start: got %b want 1", nm, busy);
        else pass_cnt++;
        wait_done(n, bok);
        total_cnt++;
        if (n !== 64 || !bok) $display("FAIL %s_latency: got %0d busy_ok=%0d want 64 1", nm, n, bok);
        else pass_cnt++;
        e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        total_cnt++;
        if (product !== e.p || overflow !== e.o || busy !== 1'b0)
            $display("FAIL %s_result: got p=%0d o=%b busy=%b want p=%0d o=%b busy=0", nm, product, overflow, busy, e.p, e.o);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (done !== 1'b0 || product !== e.p)
            $display("FAIL %s_done_pulse: got done=%b p=%0d want done=0 p=%0d", nm, done, product, e.p);
        else pass_cnt++;
    endtask

    task automatic test_directed();
        test_op("basic",    64'd738468,  64'd900000);
        test_op("basic2",   64'd7446525, 64'd1000000);
        test_op("zero_a",   64'd0,       64'd12345);
        test_op("zero_b",   64'hDEAD_BEEF_0000_0001, 64'd0);
        test_op("pow32",    64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000);
        test_op("max_x1",   64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        test_op("max_x2",   64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        test_op("max_max",  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        test_op("top_bit",  64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
        // Known constants, independent of the reference function.
        total_cnt++;
        if (ref_model(64'd738468, 64'd900000) !== {64'd664621200000, 1'b0})
            $display("FAIL ref_const: got %h want 664621200000", ref_model(64'd738468, 64'd900000));
        else pass_cnt++;
    endtask

    task automatic test_busy_ignore();
        int   n;
        bit   bok;
        exp_t e;
        drive_start(64'd123456789, 64'd987654321, 1'b1);
        repeat (9) @(posedge clk);
        #1;
        a     = 64'd55;
        b     = 64'd77;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL ignore_busy: got %b want 1", busy);
        else pass_cnt++;
        wait_done(n, bok);
        total_cnt++;
        if (n + 10 !== 64) $display("FAIL ignore_latency: got %0d want 64", n + 10);
        else pass_cnt++;
        e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        total_cnt++;
        if (product !== e.p || overflow !== e.o)
            $display("FAIL ignore_result: got p=%0d o=%b want p=%0d o=%b", product, overflow, e.p, e.o);
        else pass_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int   n;
        bit   bok;
        exp_t e1;
        exp_t e2;
        a     = 64'd3000000007;
        b     = 64'd5000000011;
        start = 1'b1;
        sb_q.push_back(ref_model(a, b));
        @(posedge clk);
        #1;
        // Start stays high; second operand set is launched from DONE.
        a = 64'hFFFF_0000_FFFF_0000;
        b = 64'd65537;
        sb_q.push_back(ref_model(a, b));
        wait_done(n, bok);
        e1 = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        total_cnt++;
        if (n !== 64 || product !== e1.p || overflow !== e1.o)
            $display("FAIL b2b_first: got n=%0d p=%0d o=%b want n=64 p=%0d o=%b", n, product, overflow, e1.p, e1.o);
        else pass_cnt++;
        @(posedge clk);
        #1;
        start = 1'b0;
        total_cnt++;
        if (busy !== 1'b1 || done !== 1'b0 || product !== e1.p)
            $display("FAIL b2b_restart: got busy=%b done=%b p=%0d want 1 0 %0d", busy, done, product, e1.p);
        else pass_cnt++;
        wait_done(n, bok);
        e2 = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        total_cnt++;
        if (n !== 64 || product !== e2.p || overflow !== e2.o)
            $display("FAIL b2b_second: got n=%0d p=%0d o=%b want n=64 p=%0d o=%b", n, product, overflow, e2.p, e2.o);
        else pass_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_run();
        int done_seen;
        done_seen = 0;
        drive_start(64'd99999, 64'd88888, 1'b0);
        repeat (29) @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({busy, done, product, overflow} !== 67'd0)
            $display("FAIL midrun_reset: got busy=%b done=%b p=%0d o=%b want all 0", busy, done, product, overflow);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_seen++;
        end
        total_cnt++;
        if (done_seen !== 0) $display("FAIL midrun_no_done: got %0d pulses want 0", done_seen);
        else pass_cnt++;
        test_op("after_rst", 64'd7446525, 64'd1000000);
    endtask

    task automatic test_random();
        int          n;
        bit          bok;
        int          bad;
        exp_t        e;
        logic [63:0] x;
        logic [63:0] y;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            x = {$urandom, $urandom} >> $urandom_range(0, 63);
            y = {$urandom, $urandom} >> $urandom_range(0, 63);
            drive_start(x, y, 1'b1);
            wait_done(n, bok);
            e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
            total_cnt++;
            if (n !== 64 || product !== e.p || overflow !== e.o) begin
                bad++;
                if (bad <= 10)
                    $display("FAIL rand_%0d: a=%h b=%h got n=%0d p=%h o=%b want n=64 p=%h o=%b", i, x, y, n, product, overflow, e.p, e.o);
            end else pass_cnt++;
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_directed();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        total_cnt++;
        if (sb_q.size() !== 0) $display("FAIL scoreboard_empty: got %0d left want 0", sb_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
